counter_cmp_irq: RTL and testbench
==================================

// Module: counter_cmp_irq
// PURPOSE
//  Downstream consumer of the user-project counter value. Watches count_i against two
//  Wishbone-programmable compare registers and detects counter wrap.
//  Raises sticky status flags and drives user irq[2:0].
//  Sits beside the counter on the same Wishbone slave bus, decoded at its own base address.
// PARAMETERS
//  BITS       32            width of count_i and the compare registers (1..32)
//  BASE_ADDR  32'h3000_0100 byte base of the register window; adr[31:5] must match BASE_ADDR[31:5]
// PORTS
//  wb_clk_i    in   1     single clock; all state on posedge
//  wb_rst_ni   in   1     asynchronous, active-low reset
//  wbs_stb_i   in   1     Wishbone strobe
//  wbs_cyc_i   in   1     Wishbone cycle
//  wbs_we_i    in   1     write enable
//  wbs_sel_i   in   4     byte lane selects
//  wbs_dat_i   in   32    write data
//  wbs_adr_i   in   32    byte address
//  wbs_ack_o   out  1     one-cycle acknowledge
//  wbs_dat_o   out  32    read data, valid while wbs_ack_o=1
//  count_i     in   BITS  live counter value from the upstream counter
//  irq         out  3     [0]=CMP0 match, [1]=CMP1 match, [2]=wrap; level, = STATUS & IEN
// BEHAVIOUR
//  Registers (offset = adr[4:2]*4; byte-lane writes honour wbs_sel_i):
//   0x00 CTRL    [0]=EN, [3:1]=IEN[2:0]; RW; reset 0
//   0x04 STATUS  [2:0] sticky flags; write-1-to-clear; reset 0
//   0x08 CMP0 and 0x0C CMP1: RW, BITS wide, upper bits read 0; reset 0
//   0x10 SNAP    RO; returns count_q at the ack cycle
//   other offsets, or adr[31:5] != BASE_ADDR[31:5]: read 0, write ignored, still acked
//  Handshake:
//   - valid = cyc & stb.
//   - Ack is registered: wbs_ack_o <= valid & ~wbs_ack_o, so there is 1 cycle latency and
//     ack always drops for at least 1 cycle between transfers.
//   - Write takes effect on the ack edge. wbs_dat_o is registered and 0 when not acking.
//  Event detect:
//   - count_q <= count_i every cycle, regardless of EN; reset value 0.
//   - cmpN_evt = EN & (count_i==CMPN) & (count_q!=CMPN). The event fires on entry to
//     equality only, so a stalled counter produces one event, not a stream.
//   - wrap_evt = EN & count_q[BITS-1] & ~count_i[BITS-1], i.e. an MSB 1->0 transition.
//     This includes LA/Wishbone loads that cause the same transition.
//   - Each event sets STATUS[n] on the next edge.
//  Boundaries:
//   - Set and W1C in the same cycle: set wins, and the flag stays 1.
//   - CMP0==CMP1: both flags set in the same cycle.
//   - Writing CMPN equal to the current count: no event, because count_q already equals it.
//   - EN=0: no new events; existing flags are held; irq still reflects STATUS & IEN.
//   - Clearing IEN masks irq but keeps the STATUS flag.
//   - Reset asserted mid-transfer: every register, wbs_ack_o, wbs_dat_o and irq go to 0
//     immediately. A pending transfer is dropped and the master must retry.
// CONFIGURATION
//  CMP_AUTO_RELOAD_EN defined:
//   - Adds 0x14 PERIOD (RW, BITS wide, reset 0).
//   - On each cmp0_evt with PERIOD!=0, CMP0 <= CMP0 + PERIOD on the same edge, mod 2^BITS.
//   - A bus write to CMP0 in that same cycle wins over the reload.
//   - This gives periodic irq[0] without software.
//  Not defined:
//   - 0x14 reads 0 and writes are ignored.
//   - CMP0 changes only by bus write.
// TESTING
//  1. Reset: hold wb_rst_ni=0 -> all regs, irq and ack read 0. Read 0x00..0x10 -> 0 each.
//  2. CMP0=0x10, CTRL=0x3, count_i ramps 0x0E..0x12 -> STATUS=0x1 one cycle after count_i=0x10;
//     irq=3'b001; W1C 0x1 -> irq=0.
//  3. count_i held at 0x20 with CMP1=0x20, CTRL=0x5 -> exactly one set of STATUS[1].
//     W1C STATUS -> stays 0.
//  4. count_i 0xFFFFFFFF->0x0, CTRL=0x9 -> STATUS[2]=1, irq[2]=1.
//     W1C issued in the same cycle as a new wrap -> flag remains 1.
//  5. Access adr=BASE_ADDR+0x40 and adr=0x3000_0000 -> ack after 1 cycle, dat 0, no state change.
//     sel=4'b0010 write 0xAABBCCDD to CMP0 -> CMP0=0x0000CC00.
//  6. CMP_AUTO_RELOAD_EN: CMP0=0x100, PERIOD=0x100, free-running count ->
//     irq[0] flag sets at 0x100, 0x200, 0x300 (W1C between).
//     Without the macro, PERIOD reads 0 and only 0x100 fires.

Source files
------------

// File: rtl/counter_cmp_irq.sv
// Compare/wrap interrupt block on the counter's Wishbone bus; CMP0/CMP1 match and MSB-wrap set sticky STATUS flags, and irq = STATUS & IEN.
// Latency: registered ack one cycle after cyc&stb, write lands on that edge; events set STATUS on the edge after they are seen.
// Backpressure: none; every access is acked, and ack drops for a cycle between transfers. Optional feature macro: CMP_AUTO_RELOAD_EN.
module counter_cmp_irq #(
    parameter int          BITS      = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] count_i,
    output logic [2:0]      irq
);

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_STATUS = 3'd1;
    localparam logic [2:0] IDX_CMP0   = 3'd2;
    localparam logic [2:0] IDX_CMP1   = 3'd3;
    localparam logic [2:0] IDX_SNAP   = 3'd4;
    localparam logic [2:0] IDX_PERIOD = 3'd5;

    logic            en_q;
    logic [2:0]      ien_q;
    logic [2:0]      status_q;
    logic [BITS-1:0] cmp0_q;
    logic [BITS-1:0] cmp1_q;
    logic [BITS-1:0] count_q;

    logic            valid;
    logic            acc;
    logic            hit;
    logic            wr;
    logic [2:0]      idx;
    logic [31:0]     bmask;
    logic [2:0]      w1c;
    logic            cmp0_evt;
    logic            cmp1_evt;
    logic            wrap_evt;
    logic [31:0]     cmp0_merged;
    logic [31:0]     cmp1_merged;
    logic [31:0]     rdata;
    logic            unused_adr;

    // Zero-extend a BITS-wide register value onto the 32-bit bus.
    function automatic logic [31:0] ext(input logic [BITS-1:0] v);
        logic [31:0] r;
        r          = '0;
        r[BITS-1:0] = v;
        return r;
    endfunction

    assign valid      = wbs_cyc_i & wbs_stb_i;
    assign acc        = valid & ~wbs_ack_o;
    assign hit        = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign wr         = acc & wbs_we_i & hit;
    assign idx        = wbs_adr_i[4:2];
    assign bmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign unused_adr = ^wbs_adr_i[1:0];

    // Events fire only on entry to equality, so a stalled counter gives one event.
    assign cmp0_evt = en_q & (count_i == cmp0_q) & (count_q != cmp0_q);
    assign cmp1_evt = en_q & (count_i == cmp1_q) & (count_q != cmp1_q);
    assign wrap_evt = en_q & count_q[BITS-1] & ~count_i[BITS-1];

    assign w1c = (wr && idx == IDX_STATUS && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;
    assign irq = status_q & ien_q;

    // Byte-lane merge of write data into the compare registers.
    always_comb begin
        cmp0_merged = (ext(cmp0_q) & ~bmask) | (wbs_dat_i & bmask);
        cmp1_merged = (ext(cmp1_q) & ~bmask) | (wbs_dat_i & bmask);
    end

`ifdef CMP_AUTO_RELOAD_EN
    logic [BITS-1:0] period_q;
    logic [31:0]     period_merged;
    logic            reload;

    assign reload = cmp0_evt & (period_q != '0);

    // Byte-lane merge for the reload period.
    always_comb begin
        period_merged = (ext(period_q) & ~bmask) | (wbs_dat_i & bmask);
    end

    // Period register; bus-writable only.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            period_q <= '0;
        end else if (wr && idx == IDX_PERIOD) begin
            period_q <= period_merged[BITS-1:0];
        end
    end

    // CMP0: a bus write in the same cycle beats the automatic reload.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cmp0_q <= '0;
        end else if (wr && idx == IDX_CMP0) begin
            cmp0_q <= cmp0_merged[BITS-1:0];
        end else if (reload) begin
            cmp0_q <= cmp0_q + period_q;
        end
    end
`else
    // CMP0 changes only by bus write.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cmp0_q <= '0;
        end else if (wr && idx == IDX_CMP0) begin
            cmp0_q <= cmp0_merged[BITS-1:0];
        end
    end
`endif

    // Control, CMP1, counter snapshot and sticky status (set beats clear).
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            en_q     <= 1'b0;
            ien_q    <= 3'b000;
            cmp1_q   <= '0;
            count_q  <= '0;
            status_q <= 3'b000;
        end else begin
            count_q  <= count_i;
            status_q <= (status_q & ~w1c) | {wrap_evt, cmp1_evt, cmp0_evt};
            if (wr && idx == IDX_CTRL && wbs_sel_i[0]) begin
                en_q  <= wbs_dat_i[0];
                ien_q <= wbs_dat_i[3:1];
            end
            if (wr && idx == IDX_CMP1) begin
                cmp1_q <= cmp1_merged[BITS-1:0];
            end
        end
    end

    // Read mux; undecoded addresses and unmapped offsets read 0.
    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (idx)
                IDX_CTRL:   rdata = {28'h0, ien_q, en_q};
                IDX_STATUS: rdata = {29'h0, status_q};
                IDX_CMP0:   rdata = ext(cmp0_q);
                IDX_CMP1:   rdata = ext(cmp1_q);
                IDX_SNAP:   rdata = ext(count_q);
`ifdef CMP_AUTO_RELOAD_EN
                IDX_PERIOD: rdata = ext(period_q);
`endif
                default:    rdata = 32'h0;
            endcase
        end
    end

    // Registered ack and read data; data is 0 whenever not acking.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_counter_cmp_irq.sv
// Directed bench for counter_cmp_irq: register access, compare/wrap events, masking, reset.
// Bus transfers are driven on the falling edge and sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants.
module tb_counter_cmp_irq;

    localparam logic [31:0] BASE   = 32'h3000_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_CMP0 = BASE + 32'h08;
    localparam logic [31:0] A_CMP1 = BASE + 32'h0C;
    localparam logic [31:0] A_SNAP = BASE + 32'h10;
    localparam logic [31:0] A_PER  = BASE + 32'h14;
`ifdef CMP_AUTO_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = 32'h0;
    logic [31:0] adr = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] count = 32'h0;
    logic [2:0]  irq;
    logic [31:0] r;

    int checks = 0;
    int failures = 0;

    counter_cmp_irq #(.BITS(32), .BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (wdat),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .count_i   (count),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One bus transfer; count_i takes cnt on the same edge the request is driven.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] cnt, output logic [31:0] q);
        int n;
        bit got;
        n   = 0;
        got = 0;
        q   = 32'hDEAD_BEEF;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; count = cnt;
        while (!got && n < 8) begin
            @(posedge clk);
            #1;
            n++;
            if (ack) begin
                got = 1;
                q   = rdat;
            end
        end
        check("ack_latency", n, 1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        xfer(1'b1, a, d, 4'hF, count, q);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        xfer(1'b0, a, 32'h0, 4'hF, count, q);
    endtask

    task automatic step(input logic [31:0] cnt);
        @(negedge clk);
        count = cnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ack", {31'h0, ack}, 0);
        check("rst_dat", rdat, 0);
        check("rst_irq", {29'h0, irq}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 32'(i * 4), r);
            check("rst_reg", r, 0);
        end

        // CMP0 match on a ramp
        wr(A_CMP0, 32'h10);
        wr(A_CTRL, 32'h3);
        step(32'h0E); check("ramp_0e", {29'h0, irq}, 0);
        step(32'h0F); check("ramp_0f", {29'h0, irq}, 0);
        step(32'h10); check("ramp_10", {29'h0, irq}, 3'b001);
        step(32'h11);
        step(32'h12);
        rd(A_STAT, r); check("ramp_stat", r, 32'h1);
        wr(A_STAT, 32'h1);
        check("ramp_w1c_irq", {29'h0, irq}, 0);

        // Stalled counter on CMP1 gives one event only
        wr(A_CTRL, 32'h5);
        wr(A_CMP1, 32'h20);
        step(32'h20); check("stall_set", {29'h0, irq}, 3'b010);
        step(32'h20);
        step(32'h20);
        wr(A_STAT, 32'h2);
        step(32'h20);
        step(32'h20);
        check("stall_irq", {29'h0, irq}, 0);
        rd(A_STAT, r); check("stall_stat", r, 0);
        // Writing CMP0 equal to the current count raises nothing
        wr(A_CMP0, 32'h20);
        step(32'h20);
        step(32'h20);
        rd(A_STAT, r); check("cmp_eq_count", r, 0);

        // Wrap detection and set-beats-clear
        wr(A_CTRL, 32'h9);
        step(32'hFFFF_FFFF); check("wrap_pre", {29'h0, irq}, 0);
        step(32'h0);         check("wrap_set", {29'h0, irq}, 3'b100);
        wr(A_STAT, 32'h4);
        check("wrap_w1c", {29'h0, irq}, 0);
        step(32'hFFFF_FFFF);
        xfer(1'b1, A_STAT, 32'h4, 4'hF, 32'h0, r);
        check("wrap_set_wins", {29'h0, irq}, 3'b100);
        rd(A_STAT, r); check("wrap_stat", r, 32'h4);
        wr(A_STAT, 32'h4);

        // Decode misses and byte lanes
        wr(BASE + 32'h40, 32'hFFFF_FFFF);
        rd(BASE + 32'h40, r); check("miss_hi_rd", r, 0);
        wr(32'h3000_0000, 32'h0);
        rd(32'h3000_0000, r); check("miss_lo_rd", r, 0);
        rd(A_CTRL, r); check("miss_ctrl", r, 32'h9);
        rd(BASE + 32'h1C, r); check("unmapped_rd", r, 0);
        wr(A_CMP0, 32'h0);
        xfer(1'b1, A_CMP0, 32'hAABB_CCDD, 4'b0010, count, r);
        rd(A_CMP0, r); check("byte_lane", r, 32'h0000_CC00);
        check("miss_irq", {29'h0, irq}, 0);

        // Held request: ack must drop between back-to-back transfers
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CTRL;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("ack_toggle", {31'h0, ack}, {31'h0, ~i[0]});
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;

        // Equal compares, EN=0 hold, IEN masking
        wr(A_CMP1, 32'hCC00);
        wr(A_CTRL, 32'h3);
        step(32'hCC00); check("dual_irq", {29'h0, irq}, 3'b001);
        rd(A_STAT, r); check("dual_stat", r, 32'h3);
        wr(A_CTRL, 32'h2);
        check("en0_hold_irq", {29'h0, irq}, 3'b001);
        wr(A_STAT, 32'h3);
        step(32'hCC01);
        step(32'hCC00);
        rd(A_STAT, r); check("en0_no_evt", r, 0);
        wr(A_CTRL, 32'h3);
        step(32'hCC01);
        step(32'hCC00); check("re_en_irq", {29'h0, irq}, 3'b001);
        wr(A_CTRL, 32'h1);
        check("ien_mask", {29'h0, irq}, 0);
        rd(A_STAT, r); check("ien_keep", r, 32'h3);

        // Snapshot
        step(32'h1234);
        rd(A_SNAP, r); check("snap", r, 32'h1234);

        // Auto reload (or its absence)
        wr(A_STAT, 32'h7);
        wr(A_CTRL, 32'h3);
        step(32'hFF);
        wr(A_CMP0, 32'h100);
        wr(A_PER, 32'h100);
        rd(A_PER, r); check("period_rd", r, RELOAD ? 32'h100 : 32'h0);
        step(32'h100); check("per_100", {29'h0, irq}, 3'b001);
        rd(A_CMP0, r); check("per_cmp0", r, RELOAD ? 32'h200 : 32'h100);
        wr(A_STAT, 32'h1);
        step(32'h200); check("per_200", {29'h0, irq}, RELOAD ? 3'b001 : 3'b000);
        wr(A_STAT, 32'h1);
        step(32'h300); check("per_300", {29'h0, irq}, RELOAD ? 3'b001 : 3'b000);
        wr(A_STAT, 32'h1);
        rd(A_CMP0, r); check("per_cmp0_end", r, RELOAD ? 32'h400 : 32'h100);

        // Reset in the middle of an acked transfer
        wr(A_CTRL, 32'h5);
        step(32'hCC00); check("pre_rst_irq", {29'h0, irq}, 3'b010);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CTRL;
        @(posedge clk);
        #1;
        check("pre_rst_ack", {31'h0, ack}, 1);
        check("pre_rst_dat", rdat, 32'h5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", {31'h0, ack}, 0);
        check("mid_rst_dat", rdat, 0);
        check("mid_rst_irq", {29'h0, irq}, 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_CTRL, r); check("post_rst_ctrl", r, 0);
        rd(A_CMP1, r); check("post_rst_cmp1", r, 0);
        rd(A_STAT, r); check("post_rst_stat", r, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
